// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute control sequencer for a 16-bit multi-cycle single-bus CPU.
// Optional macro CTRL_ILLEGAL_TRAP_EN: an illegal opcode halts instead of executing as a NOP.
module cpu_control_fsm #(
    parameter int unsigned REG_SEL_W   = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [15:0]               ir_in,
    input  logic                      mem_ready,
    output logic                      pc_read,
    output logic                      pc_write,
    output logic                      pc_inc,
    output logic                      mar_write,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      ir_write,
    output logic                      ir_read,
    output logic [2**REG_SEL_W-1:0]   reg_read,
    output logic [2**REG_SEL_W-1:0]   reg_write,
    output logic                      a_write,
    output logic                      alu_sub,
    output logic                      g_write,
    output logic                      g_read,
    output logic                      instr_done,
    output logic                      halted,
    output logic                      bus_error,
    output logic                      illegal
);

    localparam int unsigned NREG = 2**REG_SEL_W;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_MOV   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_LDI   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_DEC, S_MV, S_A0, S_A1, S_A2,
        S_M0, S_M1, S_I0, S_I1, S_J0, S_HLT
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_wait_cnt;
    logic                   r_bus_error;
    logic                   r_illegal;

    logic [3:0]             w_opcode;
    logic [REG_SEL_W-1:0]   w_rx;
    logic [REG_SEL_W-1:0]   w_ry;
    logic [NREG-1:0]        w_rx_oh;
    logic [NREG-1:0]        w_ry_oh;
    logic                   w_in_wait;
    logic                   w_timeout;
    logic                   w_illegal_op;
    logic                   w_unused_ir;

    assign w_opcode    = ir_in[15:12];
    assign w_rx        = ir_in[8 +: REG_SEL_W];
    assign w_ry        = ir_in[4 +: REG_SEL_W];
    assign w_rx_oh     = {{(NREG-1){1'b0}}, 1'b1} << w_rx;
    assign w_ry_oh     = {{(NREG-1){1'b0}}, 1'b1} << w_ry;
    assign w_unused_ir = ^ir_in;

    assign w_illegal_op = (w_opcode >= 4'h8) && (w_opcode <= 4'hE);
    assign w_in_wait    = (r_state == S_F1) || (r_state == S_M1) || (r_state == S_I1);
    // Timeout fires on the MEM_TIMEOUT-th cycle in a wait state; mem_ready in that cycle still wins.
    assign w_timeout    = w_in_wait && !mem_ready && (r_wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_bus_error <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (w_in_wait && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
            if ((r_state == S_DEC) && w_illegal_op) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (run) w_next = S_F0;
            S_F0:   w_next = S_F1;
            S_F1: begin
                if (mem_ready)      w_next = S_DEC;
                else if (w_timeout) w_next = S_HLT;
            end
            S_DEC: begin
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = S_M0;
                    OP_MOV:            w_next = S_MV;
                    OP_ADD, OP_SUB:    w_next = S_A0;
                    OP_LDI:            w_next = S_I0;
                    OP_JMP:            w_next = S_J0;
                    OP_HALT:           w_next = S_HLT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        if (w_illegal_op) w_next = S_HLT;
`endif
                    end
                endcase
            end
            S_A0:   w_next = S_A1;
            S_A1:   w_next = S_A2;
            S_M0:   w_next = S_M1;
            S_I0:   w_next = S_I1;
            S_M1, S_I1: if (w_timeout) w_next = S_HLT;
            S_HLT:  w_next = S_HLT;
            default: w_next = r_state;
        endcase
        // Every instruction-completing cycle returns to fetch or idles on run.
        if (instr_done) begin
            w_next = run ? S_F0 : S_IDLE;
        end
    end

    always_comb begin
        pc_read    = 1'b0;
        pc_write   = 1'b0;
        pc_inc     = 1'b0;
        mar_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_read   = '0;
        reg_write  = '0;
        a_write    = 1'b0;
        alu_sub    = 1'b0;
        g_write    = 1'b0;
        g_read     = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_F0: begin
                pc_read   = 1'b1;
                mar_write = 1'b1;
            end
            S_F1: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                end
            end
            S_DEC: begin
                if (w_opcode == OP_NOP) begin
                    instr_done = 1'b1;
                end
`ifndef CTRL_ILLEGAL_TRAP_EN
                if (w_illegal_op) begin
                    instr_done = 1'b1;
                end
`endif
            end
            S_MV: begin
                reg_read   = w_ry_oh;
                reg_write  = w_rx_oh;
                instr_done = 1'b1;
            end
            S_A0: begin
                reg_read = w_rx_oh;
                a_write  = 1'b1;
            end
            S_A1: begin
                reg_read = w_ry_oh;
                g_write  = 1'b1;
                alu_sub  = (w_opcode == OP_SUB);
            end
            S_A2: begin
                g_read     = 1'b1;
                reg_write  = w_rx_oh;
                instr_done = 1'b1;
            end
            S_M0: begin
                reg_read  = w_ry_oh;
                mar_write = 1'b1;
            end
            S_M1: begin
                if (w_opcode == OP_STORE) begin
                    reg_read  = w_rx_oh;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                    end
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        reg_write  = w_rx_oh;
                        instr_done = 1'b1;
                    end
                end
            end
            S_I0: begin
                pc_read   = 1'b1;
                mar_write = 1'b1;
            end
            S_I1: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    reg_write  = w_rx_oh;
                    pc_inc     = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_J0: begin
                reg_read   = w_rx_oh;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ir_read   = 1'b0;
    assign halted    = (r_state == S_HLT);
    assign bus_error = r_bus_error;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: per-instruction expected enable traces built from the ISA tables.
module tb_cpu_control_fsm;

    localparam int TO_CYC = 15;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       pc_read, pc_write, pc_inc, mar_write;
        logic       mem_read, mem_write, ir_write, ir_read;
        logic [3:0] reg_read, reg_write;
        logic       a_write, alu_sub, g_write, g_read;
        logic       instr_done, halted, bus_error, illegal;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b1;
    logic [15:0] ir_in = '0;
    logic        mem_ready = 1'b1;
    logic pc_read, pc_write, pc_inc, mar_write, mem_read, mem_write, ir_write, ir_read;
    logic [3:0] reg_read, reg_write;
    logic a_write, alu_sub, g_write, g_read, instr_done, halted, bus_error, illegal;

    cpu_control_fsm #(.REG_SEL_W(2), .MEM_TIMEOUT(TO_CYC)) dut (
        .clk(clk), .reset(reset), .run(run), .ir_in(ir_in), .mem_ready(mem_ready),
        .pc_read(pc_read), .pc_write(pc_write), .pc_inc(pc_inc), .mar_write(mar_write),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .ir_read(ir_read),
        .reg_read(reg_read), .reg_write(reg_write), .a_write(a_write), .alu_sub(alu_sub),
        .g_write(g_write), .g_read(g_read), .instr_done(instr_done), .halted(halted),
        .bus_error(bus_error), .illegal(illegal)
    );

    always #5 clk = ~clk;

    outs_t act;
    assign act = {pc_read, pc_write, pc_inc, mar_write, mem_read, mem_write, ir_write, ir_read,
                  reg_read, reg_write, a_write, alu_sub, g_write, g_read,
                  instr_done, halted, bus_error, illegal};

    outs_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    m_illegal = 1'b0;
    bit    m_berr = 1'b0;
    bit    g_run_after = 1'b1;

    task automatic check_outs(input string name, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            check_outs("outs", act, sb.pop_front());
        end
    end

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    task automatic push(input outs_t v);
        outs_t e;
        e = v;
        e.illegal   = m_illegal;
        e.bus_error = m_berr;
        sb.push_back(e);
    endtask

    // One clock cycle: mr = 0/1 drives mem_ready, 2 randomises it (don't-care cycle).
    task automatic cyc(input outs_t v, input int mr);
        @(posedge clk); #1;
        mem_ready = (mr == 2) ? 1'($urandom % 2) : 1'(mr);
        run = v.instr_done ? g_run_after : 1'($urandom % 2);
        push(v);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; run = 1'b1;
        m_illegal = 1'b0; m_berr = 1'b0;
        push('0);
        @(posedge clk); #1;
        reset = 1'b0;
        push('0);
    endtask

    task automatic halt_phase();
        outs_t v;
        v = '0; v.halted = 1'b1;
        repeat (3) cyc(v, 2);
        do_reset();
    endtask

    task automatic after_done(input int idle_n);
        if (!g_run_after) begin
            for (int k = 0; k < idle_n; k++) begin
                @(posedge clk); #1;
                mem_ready = 1'($urandom % 2);
                run = (k == idle_n - 1);
                push('0);
            end
        end
    endtask

    task automatic wait_step(input outs_t v, input outs_t f, input int waits, output bit to);
        to = 1'b0;
        if (waits >= TO_CYC) begin
            repeat (TO_CYC) cyc(v, 0);
            m_berr = 1'b1;
            to = 1'b1;
        end else begin
            repeat (waits) cyc(v, 0);
            cyc(f, 1);
        end
    endtask

    task automatic exec(input logic [15:0] w, input int wf, input int we,
                        input bit run_after, input int idle_n);
        logic [3:0] op;
        int rx, ry;
        outs_t v, f;
        bit to, ill;
        op = w[15:12]; rx = int'(w[9:8]); ry = int'(w[5:4]);
        g_run_after = run_after;
        v = '0; v.pc_read = 1'b1; v.mar_write = 1'b1;
        cyc(v, 2);
        ir_in = w;
        v = '0; v.mem_read = 1'b1; f = v; f.ir_write = 1'b1; f.pc_inc = 1'b1;
        wait_step(v, f, wf, to);
        if (to) begin halt_phase(); return; end
        ill = (op >= 4'h8) && (op <= 4'hE);
        v = '0;
        v.instr_done = (op == 4'h0) || (ill && !TRAP);
        cyc(v, 2);
        if (ill) m_illegal = 1'b1;
        if (op == 4'hF || (ill && TRAP)) begin halt_phase(); return; end
        case (op)
            4'h1, 4'h2: begin
                v = '0; v.reg_read = oh(ry); v.mar_write = 1'b1;
                cyc(v, 2);
                v = '0;
                if (op == 4'h1) begin
                    v.mem_read = 1'b1; f = v; f.reg_write = oh(rx);
                end else begin
                    v.reg_read = oh(rx); v.mem_write = 1'b1; f = v;
                end
                f.instr_done = 1'b1;
                wait_step(v, f, we, to);
                if (to) begin halt_phase(); return; end
            end
            4'h3: begin
                v = '0; v.reg_read = oh(ry); v.reg_write = oh(rx); v.instr_done = 1'b1;
                cyc(v, 2);
            end
            4'h4, 4'h5: begin
                v = '0; v.reg_read = oh(rx); v.a_write = 1'b1; cyc(v, 2);
                v = '0; v.reg_read = oh(ry); v.g_write = 1'b1; v.alu_sub = (op == 4'h5); cyc(v, 2);
                v = '0; v.g_read = 1'b1; v.reg_write = oh(rx); v.instr_done = 1'b1; cyc(v, 2);
            end
            4'h6: begin
                v = '0; v.pc_read = 1'b1; v.mar_write = 1'b1; cyc(v, 2);
                v = '0; v.mem_read = 1'b1; f = v;
                f.reg_write = oh(rx); f.pc_inc = 1'b1; f.instr_done = 1'b1;
                wait_step(v, f, we, to);
                if (to) begin halt_phase(); return; end
            end
            4'h7: begin
                v = '0; v.reg_read = oh(rx); v.pc_write = 1'b1; v.instr_done = 1'b1;
                cyc(v, 2);
            end
            default: begin
            end
        endcase
        after_done(idle_n);
    endtask

    task automatic abort_sub();
        outs_t v;
        g_run_after = 1'b1;
        v = '0; v.pc_read = 1'b1; v.mar_write = 1'b1; cyc(v, 2);
        ir_in = 16'h5230;
        v = '0; v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_inc = 1'b1; cyc(v, 1);
        v = '0; cyc(v, 2);
        v = '0; v.reg_read = 4'b0100; v.a_write = 1'b1; cyc(v, 2);
        v = '0; v.reg_read = 4'b1000; v.g_write = 1'b1; v.alu_sub = 1'b1; cyc(v, 2);
        @(negedge clk); #2;
        reset = 1'b1; run = 1'b0;
        m_illegal = 1'b0; m_berr = 1'b0;
        #1;
        check_outs("async_reset", act, '0);
        @(posedge clk); #1; push('0);
        @(posedge clk); #1; reset = 1'b0; push('0);
        repeat (3) begin @(posedge clk); #1; push('0); end
        @(posedge clk); #1; run = 1'b1; push('0);
    endtask

    initial begin
        logic [3:0] op;
        int r, wf, we;
        do_reset();
        repeat (4) exec(16'h0000, 0, 0, 1'b1, 1);
        exec(16'h4120, 0, 0, 1'b1, 1);
        exec(16'h1230, 0, 3, 1'b1, 1);
        exec(16'h2310, 1, 2, 1'b0, 2);
        exec(16'h3110, 0, 0, 1'b1, 1);
        exec(16'h6200, 0, TO_CYC - 1, 1'b1, 1);
        exec(16'h7300, 2, 0, 1'b0, 1);
        exec(16'h9000, 0, 0, 1'b1, 1);
        exec(16'h5230, 0, 0, 1'b1, 1);
        exec(16'h0000, TO_CYC, 0, 1'b1, 1);
        abort_sub();
        exec(16'hF000, 0, 0, 1'b1, 1);
        exec(16'h2000, 0, TO_CYC, 1'b1, 1);
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom % 20);
            if (r < 16)       op = 4'(r % 8);
            else if (r < 19)  op = 4'(8 + $urandom % 7);
            else              op = 4'hF;
            wf = ($urandom % 12 == 0) ? TO_CYC - 1 + int'($urandom % 2) : int'($urandom % 3);
            we = ($urandom % 8 == 0)  ? TO_CYC - 1 + int'($urandom % 2) : int'($urandom % 4);
            exec({op, 12'($urandom)}, wf, we, ($urandom % 4) != 0, 1 + int'($urandom % 3));
        end
        @(negedge clk); @(negedge clk); #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
